// File: rtl/alu_mdu_unit.sv
// alu_mdu_unit: EX-stage execute unit. Decodes ALUOp/funct and computes the
// result itself. Simple ops register their result one edge after start.
// mult/multu/div/divu iterate one bit per cycle and write the HI/LO registers.
//
// Parameters:
//   WIDTH  operand/result/HI/LO width (>=4, even)
//   CNT_W  iteration counter width (2**CNT_W > WIDTH)
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   start           request, sampled only while busy=0
//   ALUOp, funct    00 add, 01 sub, 11 and, 10 decode funct
//   a, b            operands (rs, rt/imm)
//   result, zero    registered result and (result==0)
//   busy, done      multi-cycle op in flight / one-cycle completion pulse
//   hi, lo          architectural HI/LO registers
//   ovf             signed add/sub overflow (only with ALU_MDU_OVF_EN defined)
// Optional feature macro: ALU_MDU_OVF_EN
module alu_mdu_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       ALUOp,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
`ifdef ALU_MDU_OVF_EN
  ,
  output logic             ovf
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2} state_t;

  localparam int W2 = 2 * WIDTH;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return ~v + WIDTH'(1);
  endfunction

  function automatic logic [W2-1:0] neg_w2(input logic [W2-1:0] v);
    return ~v + W2'(1);
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, opb_q, opb_d;
  logic             neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d, div0_q, div0_d;
  logic [WIDTH-1:0] result_q, result_d, hi_q, hi_d, lo_q, lo_d;
  logic             zero_q, zero_d, done_q, done_d;

  logic signed [WIDTH-1:0] a_s, b_s;
  logic [WIDTH-1:0] sum, dif, alu_res, a_mag, b_mag;
  logic             sel_add, sel_sub, op_mul, op_div, op_sgn;

  assign a_s = a;
  assign b_s = b;
  assign sum = a + b;
  assign dif = a - b;

`ifdef ALU_MDU_OVF_EN
  logic ovf_q, ovf_d, alu_ovf;
  assign alu_ovf = (sel_add && (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1])) ||
                   (sel_sub && (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]));
`endif

  // Decode stage: single-cycle result and multi-cycle operand preparation
  always_comb begin
    alu_res = '0;
    sel_add = 1'b0;
    sel_sub = 1'b0;
    op_mul  = 1'b0;
    op_div  = 1'b0;
    op_sgn  = 1'b0;
    case (ALUOp)
      2'b00: sel_add = 1'b1;
      2'b01: sel_sub = 1'b1;
      2'b11: alu_res = a & b;
      default: begin
        case (funct)
          F_ADD:   sel_add = 1'b1;
          F_SUB:   sel_sub = 1'b1;
          F_AND:   alu_res = a & b;
          F_OR:    alu_res = a | b;
          F_XOR:   alu_res = a ^ b;
          F_NOR:   alu_res = ~(a | b);
          F_SLT:   alu_res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
          F_SLTU:  alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
          F_MFHI:  alu_res = hi_q;
          F_MFLO:  alu_res = lo_q;
          F_MULT:  begin op_mul = 1'b1; op_sgn = 1'b1; end
          F_MULTU: op_mul = 1'b1;
          F_DIV:   begin op_div = 1'b1; op_sgn = 1'b1; end
          F_DIVU:  op_div = 1'b1;
          default: alu_res = '0;
        endcase
      end
    endcase
    if (sel_add) alu_res = sum;
    if (sel_sub) alu_res = dif;
    // The iteration runs on magnitudes; signs are reapplied at completion.
    // The most-negative value negates to itself, which is its correct
    // unsigned magnitude.
    a_mag = (op_sgn && a[WIDTH-1]) ? neg_w(a) : a;
    b_mag = (op_sgn && b[WIDTH-1]) ? neg_w(b) : b;
  end

  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] step_hi, step_lo, fin_hi, fin_lo;
  logic [W2-1:0]    prod_mag, prod;

  // Iteration stage: one shift-add or restoring-divide step, plus sign fixup
  always_comb begin
    // Multiply: acc_lo holds the multiplier, acc_hi the running partial sum.
    mul_sum   = {1'b0, acc_hi_q} + {1'b0, (acc_lo_q[0] ? opb_q : {WIDTH{1'b0}})};
    // Divide: acc_hi is the partial remainder; dividend bits leave acc_lo at
    // the top while quotient bits enter at the bottom. Bit WIDTH of the
    // difference is the borrow because the remainder stays below the divisor.
    div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opb_q};
    div_ge    = ~div_diff[WIDTH];
    if (state_q == MUL) begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
    end else begin
      step_hi = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      step_lo = {acc_lo_q[WIDTH-2:0], div_ge};
    end
    prod_mag = {step_hi, step_lo};
    prod     = neg_lo_q ? neg_w2(prod_mag) : prod_mag;
    if (state_q == MUL) begin
      fin_hi = prod[W2-1:WIDTH];
      fin_lo = prod[WIDTH-1:0];
    end else begin
      // With a zero divisor every step subtracts nothing, so the remainder
      // ends as |a|; the dividend-sign fixup turns that back into a.
      fin_hi = neg_hi_q ? neg_w(step_hi) : step_hi;
      fin_lo = div0_q ? {WIDTH{1'b1}} : (neg_lo_q ? neg_w(step_lo) : step_lo);
    end
  end

  // Control stage: next state, counter and architectural outputs
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opb_d    = opb_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    div0_d   = div0_q;
    result_d = result_q;
    zero_d   = zero_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
`ifdef ALU_MDU_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          if (op_mul || op_div) begin
            state_d  = op_mul ? MUL : DIV;
            cnt_d    = CNT_W'(WIDTH);
            acc_hi_d = '0;
            acc_lo_d = a_mag;
            opb_d    = b_mag;
            neg_lo_d = op_sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_hi_d = op_sgn && op_div && a[WIDTH-1];
            div0_d   = op_div && (b == '0);
          end else begin
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            done_d   = 1'b1;
`ifdef ALU_MDU_OVF_EN
            ovf_d    = alu_ovf;
`endif
          end
        end
      end
      MUL, DIV: begin
        acc_hi_d = step_hi;
        acc_lo_d = step_lo;
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          hi_d     = fin_hi;
          lo_d     = fin_lo;
          result_d = fin_lo;
          zero_d   = (fin_lo == '0);
          done_d   = 1'b1;
          state_d  = IDLE;
`ifdef ALU_MDU_OVF_EN
          ovf_d    = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      div0_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
`ifdef ALU_MDU_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      div0_q   <= div0_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
`ifdef ALU_MDU_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  // Working registers are fully loaded at op start, so they need no reset.
  always_ff @(posedge clk) begin
    acc_hi_q <= acc_hi_d;
    acc_lo_q <= acc_lo_d;
    opb_q    <= opb_d;
  end

  assign result = result_q;
  assign zero   = zero_q;
  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign hi     = hi_q;
  assign lo     = lo_q;
`ifdef ALU_MDU_OVF_EN
  assign ovf    = ovf_q;
`endif

endmodule

// File: doc/alu_mdu_unit.md
Name: alu_mdu_unit

Overview:
Parametrised execute unit that decodes ALUOp/funct and performs the operation itself. It succeeds the combinational ALU-control decoder. Simple ops finish in one registered cycle. MULT/MULTU/DIV/DIVU run iteratively, one bit per cycle, with a start/busy/done handshake and write architectural HI/LO registers. It sits in the EX stage of the multi-cycle datapath; the controller stalls on busy.

Parameters:
WIDTH, 32, operand/result/HI/LO width; must be ≥4 and even.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
start  in  1  request; sampled only when busy=0
ALUOp  in  2  00 add, 01 sub, 11 and, 10 R-type (decode funct)
funct  in  6  R-type function field
a  in  WIDTH  operand A (rs)
b  in  WIDTH  operand B (rt/imm)
result  out  WIDTH  registered result
zero  out  1  registered (result==0)
busy  out  1  multi-cycle op in progress
done  out  1  one-cycle completion pulse
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high.
- Reset: result=0, zero=1, busy=0, done=0, hi=0, lo=0, state=IDLE, counter=0.
- A reset asserted during MUL/DIV aborts the operation. No done pulse is issued and HI/LO clear to 0.
- R-type funct decode (ALUOp=10):
  - 100000 add; 100010 sub; 100100 and; 100101 or; 100110 xor; 100111 nor.
  - 101010 slt (signed); 101011 sltu.
  - 010000 mfhi; 010010 mflo.
  - 011000 mult; 011001 multu; 011010 div; 011011 divu.
  - Any other funct: result=0, no HI/LO change, treated as a single-cycle op.
- Arithmetic: add/sub wrap modulo 2^WIDTH. slt/sltu return 1 or 0, zero-extended to WIDTH.
- States are IDLE, MUL, DIV.
- IDLE, start=1, single-cycle op: result/zero register at that edge (E0); done=1 for exactly the following cycle; stay IDLE.
- IDLE, start=1, mult*/div*: latch operand magnitudes and sign flags; counter=WIDTH; busy=1 at E0; go to MUL or DIV.
- MUL: shift-add, one bit per cycle. DIV: restoring division, one quotient bit per cycle. Counter decrements each edge.
- Edge E_WIDTH (counter reaches 0) completes the operation:
  - apply sign fixup; write HI/LO;
  - result=LO and zero=(LO==0);
  - busy=0, done=1 for one cycle; return to IDLE.
- Latency: single-cycle op, done 1 cycle after start; multi-cycle op, done WIDTH cycles after start, with busy high for exactly WIDTH cycles.
- mult/multu: {HI,LO} = full 2·WIDTH product.
- div/divu: LO=quotient, HI=remainder. Signed: quotient truncates toward zero; remainder takes the sign of the dividend.
- Divide by zero (signed or unsigned): LO = all ones, HI = a. No exception raised.
- Signed division of the most-negative value by -1: LO = most-negative value, HI = 0.
- start while busy=1 is ignored; operands are not re-sampled mid-operation.
- start on the same edge as done (busy already cleared at that edge) is accepted normally.
- mfhi/mflo issued the cycle after done read the newly written HI/LO.
- result, zero, hi and lo hold their values between completions.

Optional Feature:
Macro ALU_MDU_OVF_EN.
- Defined: adds output port ovf (1 bit, reset 0), registered alongside result. ovf=1 for signed overflow on add/sub: ALUOp 00/01, or funct 100000/100010. ovf=0 for every other op. Wrapped result is still written.
- Undefined: no ovf port; overflow wraps silently.

Test Plan:
1. ALUOp=10, funct=100000, a=5, b=7, start → next cycle result=12, zero=0, done=1 for one cycle, busy stays 0.
2. ALUOp=01, a=0x1234, b=0x1234 → result=0, zero=1; ALUOp=10 funct=101010 a=0xFFFFFFFF b=1 → result=1; funct=101011 → result=0.
3. mult, a=0xFFFFFFFD, b=7 → busy=1 for 32 cycles, done at cycle 32, HI=0xFFFFFFFF, LO=0xFFFFFFEB, result=0xFFFFFFEB; then mfhi → result=0xFFFFFFFF.
4. div, a=0xFFFFFFF9 (-7), b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then divu, a=9, b=0 → LO=0xFFFFFFFF, HI=9. start pulsed mid-division → ignored; done pulses once.
5. multu, a=b=0xFFFFFFFF, reset asserted at cycle 10 → next cycle busy=0, hi=lo=0, no done pulse. New add after reset completes normally.
6. With ALU_MDU_OVF_EN: add 0x7FFFFFFF+1 → result=0x80000000, ovf=1. sub 0x80000000-1 → ovf=1. and → ovf=0.
